// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide on operand magnitudes, one bit per cycle.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             addr_r,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             quot_neg;
  logic             rem_neg;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lo_acc;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag_c;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    prod_fix;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  // Issue-time magnitudes, per-cycle iteration step and final sign correction
  always_comb begin
    a_neg    = ~op[0] & a[WIDTH-1];
    b_neg    = ~op[0] & b[WIDTH-1];
    a_mag    = a_neg ? WIDTH'(-a) : a;
    b_mag_c  = b_neg ? WIDTH'(-b) : b;
    sum      = {1'b0, acc} + (lo_acc[0] ? {1'b0, b_mag} : {(WIDTH+1){1'b0}});
    shifted  = {acc, lo_acc[WIDTH-1]};
    diff     = shifted - {1'b0, b_mag};
    prod     = {acc, lo_acc};
    prod_fix = quot_neg ? PW'(-prod) : prod;
    quot_fix = quot_neg ? WIDTH'(-lo_acc) : lo_acc;
    rem_fix  = rem_neg ? WIDTH'(-acc) : acc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      quot_neg <= 1'b0;
      rem_neg  <= 1'b0;
      b_mag    <= '0;
      acc      <= '0;
      lo_acc   <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                state    <= CALC;
                cnt      <= CW'(WIDTH - 1);
                is_div   <= op[1];
                quot_neg <= a_neg ^ b_neg;
                rem_neg  <= a_neg;
                b_mag    <= b_mag_c;
                acc      <= '0;
                lo_acc   <= a_mag;
                busy     <= 1'b1;
              end
              3'd4:    hi <= a;
              3'd5:    lo <= a;
              default: ;
            endcase
          end
        end
        CALC: begin
          // Divide shifts quotient bits in from the right; multiply shifts product right
          if (is_div) begin
            if (!diff[WIDTH]) begin
              acc    <= diff[WIDTH-1:0];
              lo_acc <= {lo_acc[WIDTH-2:0], 1'b1};
            end else begin
              acc    <= shifted[WIDTH-1:0];
              lo_acc <= {lo_acc[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc    <= sum[WIDTH:1];
            lo_acc <= {sum[0], lo_acc[WIDTH-1:1]};
          end
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - CW'(1);
        end
        FIX: begin
          if (is_div) begin
            lo <= quot_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign r = addr_r ? hi : lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized ops
// against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        addr_r = 1'b0;
  logic [31:0] r;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .addr_r(addr_r), .r(r), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result {hi, lo} from the architectural definition
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    int     ix, iy;
    logic [31:0] q, rm;
    case (o)
      3'd0: begin
        sx = longint'(signed'(x));
        sy = longint'(signed'(y));
        return 64'(sx * sy);
      end
      3'd1: return {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y == 0) begin
          q = x[31] ? 32'd1 : 32'hFFFF_FFFF;
          rm = x;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          q = x;
          rm = 32'd0;
        end else begin
          ix = int'(x);
          iy = int'(y);
          q = 32'(ix / iy);
          rm = 32'(ix % iy);
        end
        return {rm, q};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts remaining busy cycles (bounded), then checks done and HI/LO
  task automatic wait_result(input string tag, input int exp_cycles, input logic [63:0] exp);
    int n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 64'(n), 64'(exp_cycles));
    check({tag, "_done"}, 64'(done), 64'd1);
    addr_r = 1'b1; #1;
    check({tag, "_hi"}, 64'(r), 64'(exp[63:32]));
    addr_r = 1'b0; #1;
    check({tag, "_lo"}, 64'(r), 64'(exp[31:0]));
  endtask

  task automatic md(input string tag, input logic [2:0] o, input logic [31:0] x,
                    input logic [31:0] y, input logic [63:0] exp);
    issue(o, x, y);
    wait_result(tag, 33, exp);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          dn;

    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    addr_r = 1'b1; #1; check("rst_hi", 64'(r), 64'd0);
    addr_r = 1'b0; #1; check("rst_lo", 64'(r), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    md("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    md("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
    md("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    md("divu_zero", 3'd3, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF);
    md("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    md("div_zero_pos", 3'd2, 32'd9, 32'd0, 64'h0000_0009_FFFF_FFFF);
    md("div_zero_neg", 3'd2, 32'hFFFF_FFF7, 32'd0, 64'hFFFF_FFF7_0000_0001);

    issue(3'd4, 32'h1234_5678, 32'd0);
    check("mthi_busy", 64'(busy), 64'd0);
    start = 1'b1; op = 3'd5; a = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mtlo_done", 64'(done), 64'd0);
    addr_r = 1'b1; #1; check("mt_hi", 64'(r), 64'h1234_5678);
    addr_r = 1'b0; #1; check("mt_lo", 64'(r), 64'h9ABC_DEF0);

    issue(3'd6, 32'hDEAD_BEEF, 32'd1);
    check("nop_busy", 64'(busy), 64'd0);
    addr_r = 1'b1; #1; check("nop_hi", 64'(r), 64'h1234_5678);

    // Start while busy must be ignored
    issue(3'd3, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_result("ignored", 28, {32'd2, 32'd14});

    // Back-to-back issue in the done cycle
    start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    wait_result("b2b", 33, 64'd9);

    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 5) == 0) rb = 32'd0;
      else if ($urandom_range(0, 2) == 0) rb = 32'($urandom_range(1, 20));
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      md($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, model(ro, ra, rb));
    end

    // Asynchronous reset mid-operation
    issue(3'd1, 32'hFFFF_FFFF, 32'h1234_5678);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    addr_r = 1'b1; #0; check("arst_hi", 64'(r), 64'd0);
    addr_r = 1'b0; #0; check("arst_lo", 64'(r), 64'd0);
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      dn += int'(done);
    end
    reset = 1'b0;
    repeat (40) begin
      @(negedge clk);
      dn += int'(done);
    end
    check("arst_no_done", 64'(dn), 64'd0);
    issue(3'd5, 32'd5, 32'd0);
    addr_r = 1'b0; #1;
    check("arst_mtlo", 64'(r), 64'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised iterative multiply/divide unit with its own HI/LO result registers. It is the successor to the plain HI/LO register file in the MIPS CPU. It executes MULT/MULTU/DIV/DIVU over multiple cycles and services MTHI/MTLO in a single cycle, with a busy/done handshake. The execute stage issues an operation with a start strobe, stalls MFHI/MFLO and further mult/div issues while busy is high, and reads HI or LO combinationally.

## Interface
- WIDTH, 32, operand and HI/LO register width (even, ≥4)
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  issue strobe; sampled on rising clk when busy=0
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
- a  input  WIDTH  operand rs (dividend/multiplicand; MTHI/MTLO data)
- b  input  WIDTH  operand rt (divisor/multiplier)
- addr_r  input  1  read select: 1 = HI, 0 = LO
- r  output  WIDTH  addr_r ? hi : lo, combinational from registers
- busy  output  1  high while a mult/div is in progress
- done  output  1  one-cycle pulse in the cycle after HI/LO are written by mult/div

## Operation
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE; r therefore reads 0.
- States: IDLE, CALC, FIX.
  - IDLE plus start with op 0–3: latch operands, go to CALC, load counter=WIDTH-1.
  - CALC: one iteration per cycle for WIDTH cycles; go to FIX when counter=0.
  - FIX: sign correction, write hi/lo, return to IDLE, assert done next cycle.
- MTHI/MTLO (op 4/5) in IDLE with start: hi or lo ← a at that edge. State stays IDLE; busy and done are not asserted.
- op 6/7 with start: no effect.
- start while busy=1: ignored entirely. Operands, registers and state are unchanged.
- Multiply: radix-2 shift-add on magnitudes, 2·WIDTH-bit product; {hi,lo} ← product.
  - Signed ops (MULT, DIV): operands converted to magnitude at issue; result negated in FIX as needed.
- Divide: restoring, one quotient bit per CALC cycle; lo ← quotient, hi ← remainder.
  - Signed quotient sign = sign(a) XOR sign(b).
  - Signed remainder sign = sign(a).
- Divide by zero (b=0): lo ← all ones (unsigned) or, for DIV, −1 if a≥0 / +1 if a<0; hi ← a. Same latency as a normal divide.
- DIV of most-negative by −1: lo ← most-negative value, hi ← 0 (no trap).
- The read path is pure mux of registers, valid in every state; mid-operation hi/lo retain their previous values until FIX.
- Reset asserted mid-operation: immediately returns to IDLE, busy=0, hi=lo=0; no done pulse.

## Timing
- Issue edge E0 (start=1, busy=0). busy rises after E0 and stays high for exactly WIDTH+1 cycles (WIDTH CALC + 1 FIX).
- hi/lo update on the edge ending FIX (E0+WIDTH+1); busy falls at the same edge.
- done is high for the single cycle following that edge. The new result is on r in that cycle.
- A new start is accepted in the cycle done is high (back-to-back issue, no bubble).
- MTHI/MTLO: result visible on r in the cycle after the issue edge.
- Combinational r has zero-cycle latency from addr_r.
- Reset is asynchronous assert; deassertion is synchronised externally to clk.

## Test plan
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high for 33 cycles, then done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (−3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV a=0xFFFFFFF9 (−7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=7 b=0 -> lo=0xFFFFFFFF, hi=0x00000007 after 33 cycles. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 next cycle -> busy never high; addr_r=1 gives r=0x12345678, addr_r=0 gives r=0x9ABCDEF0.
- Start DIVU 100/7; pulse start with MULTU 3×3 at cycle 5 -> second start ignored; final lo=14, hi=2. Issue MULTU 3×3 in the done cycle -> accepted; lo=9 after 33 further cycles.
- Start MULTU; assert reset asynchronously at cycle 10 -> busy=0, r=0 immediately, no done pulse; after release, MTLO 5 reads back lo=5.
